jedro_1_reg_checker: RTL and testbench
======================================

Name: jedro_1_reg_checker

Overview:
- Synthesizable end-of-program checker for the jedro_1 core; generalises the per-instruction self-check flow into one reusable block.
- After start, counts cycles until the core halts (illegal instruction) or a cycle budget expires, waits out pipeline drain, then reads NUM_CHECKS register-file entries through a read port and compares each against its expected value.
- Reports done, pass/fail, timeout, and the index and data of the first mismatching check.
- Sits beside jedro_1_top in simulation and FPGA bring-up harnesses.

Parameters:
DATA_WIDTH, 32, register data width
REG_ADDR_WIDTH, 5, register-file address width
NUM_CHECKS, 4, number of register checks (>=1)
MAX_CYCLES, 32, run-cycle budget before timeout (>=1)
DRAIN_CYCLES, 3, cycles waited after halt/timeout (>=0)
CNT_WIDTH, 16, width of cycle counter (must hold MAX_CYCLES)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
start_i  in  1  pulse; starts a run when in IDLE or DONE
halt_i  in  1  core halt indication (decoder illegal-instruction flag)
check_en_i  in  NUM_CHECKS  per-check enable; bit k gates check k
check_addr_i  in  NUM_CHECKS*REG_ADDR_WIDTH  register address for check k (slice k)
check_val_i  in  NUM_CHECKS*DATA_WIDTH  expected value for check k (slice k)
rf_raddr_o  out  REG_ADDR_WIDTH  register-file read address
rf_rdata_i  in  DATA_WIDTH  read data, valid one cycle after rf_raddr_o
busy_o  out  1  high in any state except IDLE/DONE
done_o  out  1  high in DONE
pass_o  out  1  all enabled checks matched (valid when done_o)
timeout_o  out  1  run ended by budget, not halt
fail_idx_o  out  $clog2(NUM_CHECKS)+1  index of first mismatch
fail_data_o  out  DATA_WIDTH  actual data read at first mismatch
cycle_cnt_o  out  CNT_WIDTH  RUN cycles elapsed

Behaviour:
- Reset (async, rstn_i low): state IDLE; busy_o=0, done_o=0, pass_o=0, timeout_o=0, fail_idx_o=0, fail_data_o=0, cycle_cnt_o=0, rf_raddr_o=0. Reset mid-run aborts immediately with no report.
- Inputs check_* are sampled live; they must be stable from start until done.
- IDLE/DONE: start_i=1 -> RUN; clears cycle_cnt_o, timeout_o, pass_o, fail_*; done_o falls the next cycle. start_i in any other state is ignored.
- RUN: cycle_cnt_o increments each cycle.
  - halt_i=1 -> DRAIN; the halting cycle is counted.
  - Else if cycle_cnt_o+1 == MAX_CYCLES -> DRAIN with timeout_o=1.
  - halt and budget expiry in the same cycle -> halt wins, timeout_o=0.
- DRAIN: waits exactly DRAIN_CYCLES cycles (0 = skip), then goes to ADDR with k=0. halt_i is ignored from here on.
- ADDR: if check_en_i[k]=0, skip to the next k in the same state, one cycle per skipped check. Else drive rf_raddr_o = addr[k] and go to CMP.
- CMP: compare rf_rdata_i with val[k].
  - Mismatch -> latch fail_idx_o=k and fail_data_o=rf_rdata_i, pass_o=0, go to DONE (stop at first mismatch).
  - Match with k==NUM_CHECKS-1 -> pass_o=1, DONE.
  - Else k++, return to ADDR.
- Last check disabled in ADDR -> pass_o=1, DONE.
- All enables 0 -> pass_o=1 after drain plus NUM_CHECKS skip cycles.
- Timeout does not clear pass_o; the software/bench decides policy.
- No mismatch: fail_idx_o=NUM_CHECKS (sentinel), fail_data_o=0.
- DONE holds all outputs until start_i or reset.
- Comparison is full-width unsigned equality.
- rf_raddr_o holds its last value outside ADDR.

Test Plan:
- Core program computes x1=1, x2=0 (sltu pair) then illegal instr at run cycle 10; checks {x1=1, x2=0}, en=2'b11, DRAIN=3 -> cycle_cnt_o=10, timeout_o=0, pass_o=1, fail_idx_o=NUM_CHECKS, done_o 3+4 cycles after halt.
- Same program, expect x2=5 -> pass_o=0, fail_idx_o=1, fail_data_o=0, done_o one cycle after check-1 CMP.
- halt_i never asserts, MAX_CYCLES=32 -> DRAIN entered after cycle_cnt_o reaches 32, timeout_o=1, checks still executed.
- halt_i first asserted on cycle 32 with MAX_CYCLES=32 -> timeout_o=0.
- check_en_i=0 -> pass_o=1; rf_raddr_o never changes from 0.
- rstn_i low during CMP -> all outputs 0 immediately; start_i pulse during RUN has no effect (cycle_cnt_o not cleared); start_i in DONE reruns cleanly with fresh results.

Source files
------------

// File: rtl/jedro_1_reg_checker.sv
// rtl/jedro_1_reg_checker.sv - end-of-program register-file checker for the jedro_1 core
//
// Runs the core until it halts or the cycle budget expires, waits out pipeline
// drain, then reads NUM_CHECKS register-file entries and compares each against
// its expected value, stopping at the first mismatch.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   start_i            starts a run from IDLE or DONE
//   halt_i             core halt (illegal instruction) indication
//   check_en_i         per-check enable, bit k gates check k
//   check_addr_i       packed register addresses, slice k for check k
//   check_val_i        packed expected values, slice k for check k
//   rf_raddr_o         register-file read address
//   rf_rdata_i         register-file read data, one cycle after rf_raddr_o
//   busy_o, done_o     run in progress / results valid
//   pass_o, timeout_o  all enabled checks matched / run ended by budget
//   fail_idx_o         first mismatching check (NUM_CHECKS when none)
//   fail_data_o        data read at the first mismatch
//   cycle_cnt_o        RUN cycles elapsed

module jedro_1_reg_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_CHECKS     = 4,
    parameter int MAX_CYCLES     = 32,
    parameter int DRAIN_CYCLES   = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 start_i,
    input  logic                                 halt_i,
    input  logic [NUM_CHECKS-1:0]                check_en_i,
    input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] check_addr_i,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     check_val_i,
    output logic [REG_ADDR_WIDTH-1:0]            rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]                rf_rdata_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 pass_o,
    output logic                                 timeout_o,
    output logic [$clog2(NUM_CHECKS):0]          fail_idx_o,
    output logic [DATA_WIDTH-1:0]                fail_data_o,
    output logic [CNT_WIDTH-1:0]                 cycle_cnt_o
);

    localparam int IDXW  = $clog2(NUM_CHECKS) + 1;
    // Check index width; the slot tables are padded to a power of two so any
    // index value selects a defined (disabled) entry.
    localparam int IW    = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int NSLOT = 1 << IW;

    localparam logic [CNT_WIDTH-1:0] MAX_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [IW-1:0]        K_LAST     = IW'(NUM_CHECKS - 1);
    localparam logic [IDXW-1:0]      NO_FAIL    = IDXW'(NUM_CHECKS);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_ADDR, S_CMP, S_DONE
    } state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    drain_cnt;
    logic [IW-1:0]           k;
    logic [IW-1:0]           k_nxt;

    logic                      en_arr   [NSLOT];
    logic [REG_ADDR_WIDTH-1:0] addr_arr [NSLOT];
    logic [DATA_WIDTH-1:0]     val_arr  [NSLOT];

    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        if (s < NUM_CHECKS) begin : g_used
            assign en_arr[s]   = check_en_i[s];
            assign addr_arr[s] = check_addr_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            assign val_arr[s]  = check_val_i[s*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign en_arr[s]   = 1'b0;
            assign addr_arr[s] = '0;
            assign val_arr[s]  = '0;
        end
    end

    assign k_nxt = k + 1'b1;

    // The read address is loaded on the edge entering ADDR for an enabled
    // check, so it is valid during ADDR and the synchronous register file
    // returns data during CMP. Disabled checks never touch the address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            k           <= '0;
            rf_raddr_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            fail_idx_o  <= '0;
            fail_data_o <= '0;
            cycle_cnt_o <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state       <= S_RUN;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        timeout_o   <= 1'b0;
                        fail_idx_o  <= '0;
                        fail_data_o <= '0;
                        cycle_cnt_o <= '0;
                    end
                end
                S_RUN: begin
                    cycle_cnt_o <= cycle_cnt_o + 1'b1;
                    // halt has priority over budget expiry in the same cycle
                    if (halt_i || cycle_cnt_o == MAX_LAST) begin
                        timeout_o <= !halt_i;
                        k         <= '0;
                        drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state <= S_ADDR;
                            if (en_arr[0]) rf_raddr_o <= addr_arr[0];
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_ADDR;
                        if (en_arr[0]) rf_raddr_o <= addr_arr[0];
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (en_arr[k]) begin
                        state <= S_CMP;
                    end else if (k == K_LAST) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        pass_o      <= 1'b1;
                        fail_idx_o  <= NO_FAIL;
                        fail_data_o <= '0;
                    end else begin
                        k <= k_nxt;
                        if (en_arr[k_nxt]) rf_raddr_o <= addr_arr[k_nxt];
                    end
                end
                S_CMP: begin
                    if (rf_rdata_i != val_arr[k]) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        pass_o      <= 1'b0;
                        fail_idx_o  <= IDXW'(k);
                        fail_data_o <= rf_rdata_i;
                    end else if (k == K_LAST) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        pass_o      <= 1'b1;
                        fail_idx_o  <= NO_FAIL;
                        fail_data_o <= '0;
                    end else begin
                        state <= S_ADDR;
                        k     <= k_nxt;
                        if (en_arr[k_nxt]) rf_raddr_o <= addr_arr[k_nxt];
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_reg_checker.sv
// tb/tb_jedro_1_reg_checker.sv - scoreboard bench for jedro_1_reg_checker

module tb_jedro_1_reg_checker;

    localparam int DW   = 32;
    localparam int RAW  = 5;
    localparam int N    = 2;
    localparam int MAXC = 32;
    localparam int DRN  = 3;
    localparam int CW   = 16;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            halt;
    logic [N-1:0]    check_en;
    logic [N*RAW-1:0] check_addr;
    logic [N*DW-1:0] check_val;
    logic [RAW-1:0]  rf_raddr;
    logic [DW-1:0]   rf_rdata;
    logic            busy, done, pass, timeout;
    logic [IDXW-1:0] fail_idx;
    logic [DW-1:0]   fail_data;
    logic [CW-1:0]   cycle_cnt;

    logic [DW-1:0]   regs [32];

    jedro_1_reg_checker #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .NUM_CHECKS(N),
        .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRN), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .halt_i(halt),
        .check_en_i(check_en), .check_addr_i(check_addr), .check_val_i(check_val),
        .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
        .fail_idx_o(fail_idx), .fail_data_o(fail_data), .cycle_cnt_o(cycle_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rf_rdata <= regs[rf_raddr];

    typedef struct {
        logic            pass;
        logic            timeout;
        logic [IDXW-1:0] fidx;
        logic [DW-1:0]   fdata;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every rising done_o is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                e = exp_q.pop_front();
                check("pass",      {63'd0, pass},      {63'd0, e.pass});
                check("timeout",   {63'd0, timeout},   {63'd0, e.timeout});
                check("fail_idx",  64'(fail_idx),      64'(e.fidx));
                check("fail_data", 64'(fail_data),     64'(e.fdata));
                check("cycle_cnt", 64'(cycle_cnt),     64'(e.cnt));
            end
        end
        done_d = done;
    end

    task automatic push_exp(input logic p, input logic t, input logic [IDXW-1:0] fi,
                            input logic [DW-1:0] fd, input logic [CW-1:0] c);
        exp_t x;
        x.pass = p; x.timeout = t; x.fidx = fi; x.fdata = fd; x.cnt = c;
        exp_q.push_back(x);
    endtask

    task automatic set_checks(input logic [N-1:0] en, input logic [RAW-1:0] a0, input logic [DW-1:0] v0,
                              input logic [RAW-1:0] a1, input logic [DW-1:0] v1);
        check_en   = en;
        check_addr = {a1, a0};
        check_val  = {v1, v0};
    endtask

    task automatic start_run();
        logic was_done;
        was_done = done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (was_done) check("done_falls", {63'd0, done}, 64'd0);
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // Called right after the start edge; asserts halt for RUN cycle halt_at (0 = never).
    task automatic run_core(input int halt_at);
        if (halt_at > 0) begin
            repeat (halt_at - 1) @(negedge clk);
            halt = 1'b1;
            @(negedge clk);
            halt = 1'b0;
        end
    endtask

    task automatic wait_done(output int lat, output bit moved);
        lat = 0;
        moved = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (rf_raddr != '0) moved = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: got no done within %0d cycles expected done", lat);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {63'd0, busy},    64'd0);
        check({tag, "_done"},      {63'd0, done},    64'd0);
        check({tag, "_pass"},      {63'd0, pass},    64'd0);
        check({tag, "_timeout"},   {63'd0, timeout}, 64'd0);
        check({tag, "_fail_idx"},  64'(fail_idx),    64'd0);
        check({tag, "_fail_data"}, 64'(fail_data),   64'd0);
        check({tag, "_cycle_cnt"}, 64'(cycle_cnt),   64'd0);
        check({tag, "_raddr"},     64'(rf_raddr),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit moved;

        for (int r = 0; r < 32; r++) regs[r] = '0;
        regs[1] = 32'd1;
        regs[2] = 32'd0;
        regs[7] = 32'hdead_beef;
        rstn  = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        set_checks(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // all checks disabled: pass after drain plus two skip cycles, address untouched
        set_checks(2'b00, 5'd1, 32'd1, 5'd2, 32'd0);
        push_exp(1'b1, 1'b0, 2'd2, 32'd0, 16'd3);
        start_run();
        run_core(3);
        wait_done(lat, moved);
        check("all_off_latency", 64'(lat), 64'd5);
        check("all_off_raddr_moved", {63'd0, moved}, 64'd0);

        // x1=1, x2=0, halt on run cycle 10
        set_checks(2'b11, 5'd1, 32'd1, 5'd2, 32'd0);
        push_exp(1'b1, 1'b0, 2'd2, 32'd0, 16'd10);
        start_run();
        run_core(10);
        wait_done(lat, moved);
        check("pass_latency", 64'(lat), 64'd7);

        // expect x2=5 -> mismatch on check 1
        set_checks(2'b11, 5'd1, 32'd1, 5'd2, 32'd5);
        push_exp(1'b0, 1'b0, 2'd1, 32'd0, 16'd10);
        start_run();
        run_core(10);
        wait_done(lat, moved);
        check("fail_latency", 64'(lat), 64'd7);

        // no halt: budget expiry, checks still run and pass
        set_checks(2'b11, 5'd7, 32'hdead_beef, 5'd2, 32'd0);
        push_exp(1'b1, 1'b1, 2'd2, 32'd0, 16'd32);
        start_run();
        run_core(0);
        wait_done(lat, moved);

        // halt on cycle 32 beats budget; check 1 mismatches with nonzero data
        set_checks(2'b11, 5'd1, 32'd1, 5'd7, 32'd0);
        push_exp(1'b0, 1'b0, 2'd1, 32'hdead_beef, 16'd32);
        start_run();
        run_core(32);
        wait_done(lat, moved);

        // start pulse during RUN is ignored
        set_checks(2'b11, 5'd1, 32'd1, 5'd2, 32'd0);
        push_exp(1'b1, 1'b0, 2'd2, 32'd0, 16'd10);
        start_run();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_run_cnt", 64'(cycle_cnt), 64'd5);
        repeat (4) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_done(lat, moved);
        check("rerun_latency", 64'(lat), 64'd7);

        // reset while comparing check 0
        start_run();
        run_core(2);
        repeat (4) @(negedge clk);
        check("cmp_busy", {63'd0, busy}, 64'd1);
        check("cmp_raddr", 64'(rf_raddr), 64'd1);
        rstn = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // clean run after the aborted one, halt on the first cycle
        push_exp(1'b1, 1'b0, 2'd2, 32'd0, 16'd1);
        start_run();
        run_core(1);
        wait_done(lat, moved);
        check("post_reset_latency", 64'(lat), 64'd7);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
